// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns,
// anode masks, FSM state encoding and an anode-select helper.
// Pure package, no logic or latency of its own.
package seg_pkg;

  // Active-low segment patterns, bit6..0 = g..a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Active-low anode mask with every digit dark
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // BLANK: nothing committed since reset; SCAN: shadow holds a real value
  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_t;

  // Active-low anode word selecting digit idx, dark if that digit is disabled
  function automatic logic [3:0] anode_sel(input logic [1:0] idx, input logic en);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return en ? ~onehot : ANODES_OFF;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low 7-segment decode with a forced-blank input.
// Purely combinational, zero latency.
// No flow control; non-BCD nibbles decode to all segments off.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_cathodes
);

  // Map BCD digits to their glyphs; anything else, or a blank request, is dark
  always_comb begin
    o_cathodes = SEG_BLANK;
    if (!i_blank) begin
      case (i_nibble)
        4'd0:    o_cathodes = SEG_0;
        4'd1:    o_cathodes = SEG_1;
        4'd2:    o_cathodes = SEG_2;
        4'd3:    o_cathodes = SEG_3;
        4'd4:    o_cathodes = SEG_4;
        4'd5:    o_cathodes = SEG_5;
        4'd6:    o_cathodes = SEG_6;
        4'd7:    o_cathodes = SEG_7;
        4'd8:    o_cathodes = SEG_8;
        4'd9:    o_cathodes = SEG_9;
        default: o_cathodes = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan scheduler; optional SEG_LZB_EN blanks leading zeros.
// Outputs are registered and change on each digit-slot tick; updates become visible at the next frame boundary.
// One-deep pending slot: upd_ready is low while an accepted update waits for its frame boundary.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  input  logic [3:0]  digit_en,
  output logic [3:0]  anodes,
  output logic [6:0]  cathodes,
  output logic [1:0]  dig_sel,
  output logic        frame_done
);

  localparam int            CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_pending;
  logic          r_pend_vld;
  scan_state_t   r_state;

  logic          w_tick;
  logic          w_boundary;
  logic          w_commit;
  logic          w_xfer;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_shadow_nxt;
  logic          w_scan_nxt;
  logic [3:0]    w_nibble;
  logic          w_lzb;
  logic          w_blank;
  logic [6:0]    w_cath;

  assign w_tick       = (r_cnt == CNT_MAX);
  assign w_boundary   = w_tick && (r_idx == 2'd3);
  assign w_commit     = w_boundary && r_pend_vld;
  assign w_xfer       = upd_valid && !r_pend_vld;
  assign w_idx_nxt    = r_idx + 2'd1;
  // On a boundary the new frame already uses the committed value and state
  assign w_shadow_nxt = w_commit ? r_pending : r_shadow;
  assign w_scan_nxt   = (r_state == SCAN) || w_commit;
  assign w_nibble     = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign upd_ready    = !r_pend_vld;

`ifdef SEG_LZB_EN
  // A digit above digit0 is dark when it and every higher nibble are zero
  always_comb begin
    w_lzb = 1'b0;
    case (w_idx_nxt)
      2'd1:    w_lzb = (w_shadow_nxt[15:4]  == 12'd0);
      2'd2:    w_lzb = (w_shadow_nxt[15:8]  == 8'd0);
      2'd3:    w_lzb = (w_shadow_nxt[15:12] == 4'd0);
      default: w_lzb = 1'b0;
    endcase
  end
`else
  assign w_lzb = 1'b0;
`endif

  assign w_blank = !w_scan_nxt || w_lzb;

  seg_decode u_decode (
    .i_nibble   (w_nibble),
    .i_blank    (w_blank),
    .o_cathodes (w_cath)
  );

  // Prescaler and digit index: one slot every CLK_DIV cycles, idx cycles 0..3
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= w_idx_nxt;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Update handshake, frame-boundary commit, BLANK/SCAN state and registered pin drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending  <= 16'd0;
      r_pend_vld <= 1'b0;
      r_shadow   <= 16'd0;
      r_state    <= BLANK;
      anodes     <= ANODES_OFF;
      cathodes   <= SEG_BLANK;
      dig_sel    <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_boundary;
      if (w_commit) begin
        r_shadow   <= r_pending;
        r_pend_vld <= 1'b0;
        r_state    <= SCAN;
      end else if (w_xfer) begin
        r_pending  <= upd_data;
        r_pend_vld <= 1'b1;
      end
      if (w_tick) begin
        dig_sel  <= w_idx_nxt;
        cathodes <= w_cath;
        anodes   <= w_scan_nxt ? anode_sel(w_idx_nxt, digit_en[w_idx_nxt]) : ANODES_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4 (slot 4 cycles, frame 16 cycles).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// cyc counts rising edges since reset release; ticks land on cyc%4==0, boundaries on cyc%16==0.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = 16'd0;
  logic        upd_ready;
  logic [3:0]  digit_en = 4'b1111;
  logic [3:0]  anodes;
  logic [6:0]  cathodes;
  logic [1:0]  dig_sel;
  logic        frame_done;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] disp  = 16'd0;   // value expected on the display
  logic        scan  = 1'b0;    // display expected to be lit

  seg_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
    .upd_ready  (upd_ready),
    .digit_en   (digit_en),
    .anodes     (anodes),
    .cathodes   (cathodes),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: glyph = 7'b1000000;
      4'd1: glyph = 7'b1111001;
      4'd2: glyph = 7'b0100100;
      4'd3: glyph = 7'b0110000;
      4'd4: glyph = 7'b0011001;
      4'd5: glyph = 7'b0010010;
      4'd6: glyph = 7'b0000010;
      4'd7: glyph = 7'b1111000;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  task automatic chk_display();
    int          idx;
    logic [3:0]  e_an;
    logic [6:0]  e_ca;
    logic [15:0] upper;
    idx = (cyc / 4) % 4;
    e_an = 4'b1111;
    e_ca = 7'b1111111;
    if (scan) begin
      if (digit_en[idx]) e_an[idx] = 1'b0;
      e_ca = glyph(disp[idx*4 +: 4]);
`ifdef SEG_LZB_EN
      upper = disp >> (idx * 4);
      if (idx != 0 && upper == 16'd0) e_ca = 7'b1111111;
`else
      upper = 16'd0;
`endif
    end
    chk("dig_sel", {14'd0, dig_sel}, 16'(idx));
    chk("frame_done", {15'd0, frame_done}, {15'd0, (cyc != 0) && (cyc % 16 == 0)});
    chk("anodes", {12'd0, anodes}, {12'd0, e_an});
    chk("cathodes", {9'd0, cathodes}, {9'd0, e_ca});
  endtask

  // Advance n cycles, checking the pins each cycle; optionally commit nv on the last one
  task automatic adv(input int n, input logic upd = 1'b0, input logic [15:0] nv = 16'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (upd && i == n - 1) begin
        disp = nv;
        scan = 1'b1;
      end
      chk_display();
    end
  endtask

  task automatic chk_reset_pins();
    chk("rst_anodes", {12'd0, anodes}, 16'h000F);
    chk("rst_cathodes", {9'd0, cathodes}, 16'h007F);
    chk("rst_dig_sel", {14'd0, dig_sel}, 16'd0);
    chk("rst_frame_done", {15'd0, frame_done}, 16'd0);
    chk("rst_upd_ready", {15'd0, upd_ready}, 16'd1);
  endtask

  initial begin
    // Reset, then three blank frames
    repeat (3) @(posedge clk);
    #1;
    chk_reset_pins();
    rst = 1'b1;
    cyc = 0;
    adv(48);
    chk("idle_ready", {15'd0, upd_ready}, 16'd1);

    // 1234 accepted right after a boundary, shown from the next boundary
    upd_valid = 1'b1; upd_data = 16'h1234;
    adv(1);
    upd_valid = 1'b0; upd_data = 16'hFFFF;
    chk("1234_ready_low", {15'd0, upd_ready}, 16'd0);
    adv(15, 1'b1, 16'h1234);
    chk("1234_ready_back", {15'd0, upd_ready}, 16'd1);
    chk("1234_digit0_seg", {9'd0, cathodes}, 16'h0019);
    adv(16);

    // Back-to-back offers: 1111 taken, 2222 held until after the 1111 commit
    upd_valid = 1'b1; upd_data = 16'h1111;
    adv(1);
    upd_data = 16'h2222;
    chk("b2b_ready_low", {15'd0, upd_ready}, 16'd0);
    adv(14);
    chk("b2b_still_held", {15'd0, upd_ready}, 16'd0);
    adv(1, 1'b1, 16'h1111);
    chk("b2b_ready_after_commit", {15'd0, upd_ready}, 16'd1);
    adv(1);
    upd_valid = 1'b0;
    chk("b2b_second_taken", {15'd0, upd_ready}, 16'd0);
    adv(15, 1'b1, 16'h2222);
    chk("b2b_second_commit", {15'd0, upd_ready}, 16'd1);
    adv(16);

    // 00A5 with digit2 disabled: non-BCD nibble and leading zeros
    digit_en = 4'b1011;
    upd_valid = 1'b1; upd_data = 16'h00A5;
    adv(1);
    upd_valid = 1'b0;
    adv(15, 1'b1, 16'h00A5);
    adv(12);
    chk("00A5_digit3_anode", {12'd0, anodes}, 16'h0007);
`ifdef SEG_LZB_EN
    chk("00A5_digit3_seg", {9'd0, cathodes}, 16'h007F);
`else
    chk("00A5_digit3_seg", {9'd0, cathodes}, 16'h0040);
`endif
    adv(4);

    // Mid-frame reset with an update pending: cleared, never displayed
    digit_en = 4'b1111;
    upd_valid = 1'b1; upd_data = 16'h9999;
    adv(1);
    upd_valid = 1'b0;
    chk("9999_pending", {15'd0, upd_ready}, 16'd0);
    adv(4);
    rst = 1'b0;
    #1;
    chk_reset_pins();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc = 0;
    disp = 16'd0;
    scan = 1'b0;
    adv(15);

    // Offer held across the boundary edge itself: commits one frame later
    upd_valid = 1'b1; upd_data = 16'h0807;
    adv(1);
    upd_valid = 1'b0;
    chk("edge_xfer_pending", {15'd0, upd_ready}, 16'd0);
    adv(16, 1'b1, 16'h0807);
    chk("edge_commit_fd", {15'd0, frame_done}, 16'd1);
    chk("edge_commit_seg", {9'd0, cathodes}, 16'h0078);
    adv(16);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
